uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- Accepts a parallel byte, then drives the frame start bit, data bits, optional parity bit and stop bit(s) onto the serial line.
- Enables the external shift serializer during the data phase and multiplexes its bit stream onto tx_out.
- Sits between the host-side valid interface and the line; one bit per clk cycle, since clk is the bit-rate clock.

Parameters:
- DATA_WIDTH, 8, width of p_data; also the parity calculation width.
- STOP_BITS, 1, number of stop-bit cycles; legal values 1 or 2.

Ports:
- clk  in  1  bit-rate clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- p_data  in  DATA_WIDTH  parallel byte; sampled only on accept.
- data_valid  in  1  host request; accepted only in IDLE.
- par_en  in  1  1 = insert a parity bit; sampled on accept.
- par_typ  in  1  0 = even, 1 = odd; sampled on accept.
- ser_data  in  1  current data bit from the serializer.
- ser_done  in  1  serializer reports the last data bit is on ser_data.
- ser_en  out  1  serializer shift enable.
- busy  out  1  frame in progress.
- tx_out  out  1  serial line; idles high.
- tx_done  out  1  one-cycle pulse in the final stop-bit cycle.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. State is registered. All outputs are combinational decodes of state, except tx_out in DATA, which passes ser_data through.
- Reset (rst low, asynchronous):
  - state = IDLE; stop counter = 0; parity register = 0; latched par_en/par_typ = 0.
  - Outputs: ser_en = 0, busy = 0, tx_out = 1, tx_done = 0.
  - Reset asserted mid-frame aborts the frame immediately. tx_out returns to 1 asynchronously, and no tx_done is issued.
- IDLE:
  - tx_out = 1, busy = 0.
  - On an edge with data_valid = 1: go to START, and latch par_en, par_typ and parity_bit = (^p_data) XOR par_typ.
  - data_valid = 0: stay in IDLE.
- START: tx_out = 0, busy = 1, ser_en = 0. Exactly 1 cycle, then DATA.
- DATA:
  - ser_en = 1, tx_out = ser_data, busy = 1.
  - Stays in DATA until the edge where ser_done = 1.
  - Next state after that edge: PARITY if the latched par_en = 1, else STOP.
  - ser_done is ignored in every state other than DATA.
- PARITY: tx_out = latched parity_bit, ser_en = 0. Exactly 1 cycle, then STOP.
- STOP:
  - tx_out = 1. Lasts STOP_BITS cycles, counted by a 1-bit stop counter that is cleared on entry.
  - tx_done = 1 only in the last STOP cycle. After that cycle, next state = IDLE.
- busy = 1 in every state except IDLE.
  - Minimum gap between frames is one IDLE cycle. data_valid held high continuously gives one frame every (1 + 1 + N_data + par + STOP_BITS) cycles, where N_data = number of DATA cycles.
- p_data, par_en and par_typ changing while busy has no effect on the current frame.
- data_valid asserted during a frame is not queued. It is accepted only if still high in IDLE.
- Illegal STOP_BITS values (other than 1 or 2) are out of scope. Synthesis and simulation behaviour for them is undefined and the bench does not test them.

Test Plan:
- Reset mid-DATA: assert rst low while in DATA -> tx_out = 1, busy = 0, ser_en = 0 in the same cycle; state = IDLE after release; no tx_done pulse.
- Basic frame, no parity:
  - Stimulus: p_data = 0xA5, par_en = 0, one-cycle data_valid. Serializer model emits LSB-first bits and asserts ser_done on the 8th DATA cycle.
  - Response: tx_out = 0,1,0,1,0,0,1,0,1,1; busy high for 10 cycles; tx_done high on the 10th; ser_en high exactly 8 cycles.
- Even parity: p_data = 0x07, par_en = 1, par_typ = 0 -> parity cycle tx_out = 1; frame is 11 cycles.
- Odd parity with 2 stop bits: STOP_BITS = 2, p_data = 0x07, par_typ = 1 -> parity tx_out = 0; two stop cycles at 1; tx_done only in the second stop cycle.
- Back-to-back: data_valid held high with 0x55 then 0x0F -> exactly one IDLE cycle (tx_out = 1, busy = 0) between frames; second frame carries 0x0F. p_data changed mid-frame does not alter the first frame's parity.
- Spurious ser_done: ser_done pulsed during START, PARITY and IDLE -> no state change; DATA still lasts until ser_done is seen in DATA.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, serializer-driven data bits,
// optional parity bit and STOP_BITS stop cycles, one bit per clk.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  tx_out,
    output logic                  tx_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Stop counter value that marks the final stop cycle.
    localparam logic LAST_STOP = (STOP_BITS == 2);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       stop_cnt;
    logic       par_en_q;
    logic       parity_q;
    logic       last_stop;

    assign last_stop = (stop_cnt == LAST_STOP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_valid) state_nxt = START;
            START:   state_nxt = DATA;
            DATA:    if (ser_done) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  state_nxt = STOP;
            STOP:    if (last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Parity is resolved at accept so host-side changes mid-frame are harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            stop_cnt <= 1'b0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && data_valid) begin
                par_en_q <= par_en;
                parity_q <= (^p_data) ^ par_typ;
            end
            if (state != STOP)
                stop_cnt <= 1'b0;
            else if (!last_stop)
                stop_cnt <= 1'b1;
        end
    end

    always_comb begin
        ser_en  = 1'b0;
        busy    = 1'b1;
        tx_out  = 1'b1;
        tx_done = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            START:   tx_out = 1'b0;
            DATA: begin
                ser_en = 1'b1;
                tx_out = ser_data;
            end
            PARITY:  tx_out = parity_q;
            STOP:    tx_done = last_stop;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one instance with 1 stop bit, one with 2,
// each fed by its own LSB-first serializer model.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       spur;

    logic [1:0] ser_data;
    logic [1:0] ser_done;
    logic [1:0] ser_en;
    logic [1:0] busy;
    logic [1:0] tx_out;
    logic [1:0] tx_done;

    logic [7:0] sh [2];
    int         cnt [2];

    int vec;
    int err;

    logic [31:0] cap_tx, cap_busy, cap_done, cap_sen;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_s1 (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
        .par_en(par_en), .par_typ(par_typ), .ser_data(ser_data[0]),
        .ser_done(ser_done[0]), .ser_en(ser_en[0]), .busy(busy[0]),
        .tx_out(tx_out[0]), .tx_done(tx_done[0])
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u_s2 (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
        .par_en(par_en), .par_typ(par_typ), .ser_data(ser_data[1]),
        .ser_done(ser_done[1]), .ser_en(ser_en[1]), .busy(busy[1]),
        .tx_out(tx_out[1]), .tx_done(tx_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer model: loads on accept, raises ser_done on the 8th shift cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!busy[k] && data_valid) begin
                sh[k]  <= p_data;
                cnt[k] <= 0;
            end else if (ser_en[k]) begin
                sh[k]  <= sh[k] >> 1;
                cnt[k] <= cnt[k] + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ser_data[k] = sh[k][0];
            ser_done[k] = (ser_en[k] && cnt[k] == 7) || spur;
        end
    end

    task automatic capture(input int k, input int n);
        cap_tx = '0; cap_busy = '0; cap_done = '0; cap_sen = '0;
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = tx_out[k];
            cap_busy[i] = busy[k];
            cap_done[i] = tx_done[k];
            cap_sen[i]  = ser_en[k];
            @(negedge clk);
        end
    endtask

    // Leaves the bench at the negedge where both instances sit in START.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
        repeat (3) @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        for (int k = 0; k < 2; k++) begin
            vec++;
            if ({tx_out[k], busy[k], ser_en[k], tx_done[k]} !== 4'b1000) begin
                err++;
                $display("FAIL reset_outputs[%0d]: got %b expected 1000", k,
                         {tx_out[k], busy[k], ser_en[k], tx_done[k]});
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (busy !== 2'b00 || tx_out !== 2'b11) begin
            err++;
            $display("FAIL reset_release_idle: got busy=%b tx=%b expected 00 11", busy, tx_out);
        end
    endtask

    task automatic test_basic;
        start_frame(8'hA5, 1'b0, 1'b0);
        capture(0, 11);
        vec++; if (cap_tx !== 32'h74A) begin err++; $display("FAIL basic_tx: got %h expected 74a", cap_tx); end
        vec++; if (cap_busy !== 32'h3FF) begin err++; $display("FAIL basic_busy: got %h expected 3ff", cap_busy); end
        vec++; if (cap_done !== 32'h200) begin err++; $display("FAIL basic_done: got %h expected 200", cap_done); end
        vec++; if (cap_sen !== 32'h1FE) begin err++; $display("FAIL basic_ser_en: got %h expected 1fe", cap_sen); end
    endtask

    task automatic test_even_parity;
        start_frame(8'h07, 1'b1, 1'b0);
        capture(0, 12);
        vec++; if (cap_tx !== 32'hE0E) begin err++; $display("FAIL even_tx: got %h expected e0e", cap_tx); end
        vec++; if (cap_busy !== 32'h7FF) begin err++; $display("FAIL even_busy: got %h expected 7ff", cap_busy); end
        vec++; if (cap_done !== 32'h400) begin err++; $display("FAIL even_done: got %h expected 400", cap_done); end
    endtask

    task automatic test_odd_two_stop;
        start_frame(8'h07, 1'b1, 1'b1);
        capture(1, 13);
        vec++; if (cap_tx !== 32'h1C0E) begin err++; $display("FAIL odd2_tx: got %h expected 1c0e", cap_tx); end
        vec++; if (cap_busy !== 32'hFFF) begin err++; $display("FAIL odd2_busy: got %h expected fff", cap_busy); end
        vec++; if (cap_done !== 32'h800) begin err++; $display("FAIL odd2_done: got %h expected 800", cap_done); end
        vec++; if (cap_sen !== 32'h1FE) begin err++; $display("FAIL odd2_ser_en: got %h expected 1fe", cap_sen); end
    endtask

    task automatic test_back_to_back;
        repeat (3) @(negedge clk);
        p_data = 8'h55; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        cap_tx = '0; cap_busy = '0; cap_done = '0;
        for (int i = 0; i < 24; i++) begin
            cap_tx[i]   = tx_out[0];
            cap_busy[i] = busy[0];
            cap_done[i] = tx_done[0];
            if (i == 3)  p_data = 8'h01;
            if (i == 9)  p_data = 8'h0F;
            if (i == 12) data_valid = 1'b0;
            @(negedge clk);
        end
        vec++; if (cap_tx !== 32'hC1ECAA) begin err++; $display("FAIL b2b_tx: got %h expected c1ecaa", cap_tx); end
        vec++; if (cap_busy !== 32'h7FF7FF) begin err++; $display("FAIL b2b_busy: got %h expected 7ff7ff", cap_busy); end
        vec++; if (cap_done !== 32'h400400) begin err++; $display("FAIL b2b_done: got %h expected 400400", cap_done); end
    endtask

    task automatic test_spurious_done;
        repeat (3) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        vec++;
        if (busy[0] !== 1'b0 || tx_out[0] !== 1'b1) begin
            err++;
            $display("FAIL spur_idle: got busy=%b tx=%b expected 0 1", busy[0], tx_out[0]);
        end
        p_data = 8'h00; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        cap_tx = '0; cap_busy = '0; cap_sen = '0;
        for (int i = 0; i < 12; i++) begin
            cap_tx[i]   = tx_out[0];
            cap_busy[i] = busy[0];
            cap_sen[i]  = ser_en[0];
            spur = (i == 0 || i == 9);
            @(negedge clk);
        end
        spur = 1'b0;
        vec++; if (cap_tx !== 32'hE00) begin err++; $display("FAIL spur_tx: got %h expected e00", cap_tx); end
        vec++; if (cap_busy !== 32'h7FF) begin err++; $display("FAIL spur_busy: got %h expected 7ff", cap_busy); end
        vec++; if (cap_sen !== 32'h1FE) begin err++; $display("FAIL spur_ser_en: got %h expected 1fe", cap_sen); end
    endtask

    task automatic test_reset_mid_data;
        logic saw_done;
        start_frame(8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        vec++;
        if (tx_out[0] !== 1'b0 || ser_en[0] !== 1'b1) begin
            err++;
            $display("FAIL rst_mid_pre: got tx=%b ser_en=%b expected 0 1", tx_out[0], ser_en[0]);
        end
        #2 rst = 1'b0;
        #1;
        vec++;
        if ({tx_out[0], busy[0], ser_en[0], tx_done[0]} !== 4'b1000) begin
            err++;
            $display("FAIL rst_mid_async: got %b expected 1000",
                     {tx_out[0], busy[0], ser_en[0], tx_done[0]});
        end
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (tx_done[0] || busy[0] || !tx_out[0]) saw_done = 1'b1;
            @(negedge clk);
        end
        vec++;
        if (saw_done !== 1'b0) begin
            err++;
            $display("FAIL rst_mid_after: got activity=%b expected 0", saw_done);
        end
    endtask

    initial begin
        vec = 0; err = 0;
        rst = 1'b0; p_data = '0; data_valid = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; spur = 1'b0;
        test_reset;
        test_basic;
        test_even_parity;
        test_odd_two_stop;
        test_back_to_back;
        test_spurious_done;
        test_reset_mid_data;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
